// File: rtl/tama_pkg.sv
// tama_pkg: command codes, sequencer state and button-to-command mapping
// shared by the command path.
package tama_pkg;
    localparam logic [7:0] CMD_EAT   = 8'h65;
    localparam logic [7:0] CMD_PLAY  = 8'h70;
    localparam logic [7:0] CMD_DOC   = 8'h64;
    localparam logic [7:0] CMD_BATH  = 8'h62;
    localparam logic [7:0] CMD_SLEEP = 8'h73;
    localparam logic [7:0] CMD_WAKE  = 8'h77;
    localparam logic [7:0] CMD_NONE  = 8'h00;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} seq_state_t;
    typedef enum logic {RR_UART, RR_BTN} rr_src_t;

    function automatic logic [7:0] btn_code(input logic [2:0] idx);
        return idx == 3'd0 ? CMD_EAT  :
               idx == 3'd1 ? CMD_PLAY :
               idx == 3'd2 ? CMD_DOC  :
               idx == 3'd3 ? CMD_BATH :
               idx == 3'd4 ? CMD_SLEEP :
               idx == 3'd5 ? CMD_WAKE : CMD_NONE;
    endfunction

    function automatic logic is_cmd(input logic [7:0] b);
        return b inside {CMD_EAT, CMD_PLAY, CMD_DOC, CMD_BATH, CMD_SLEEP, CMD_WAKE};
    endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: single-clock byte FIFO with registered occupancy; a pop frees
// its slot on the same edge as a push.
module cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          do_wr, do_rd;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rp_q];
    assign do_rd   = rd_en_i && !empty_o;
    assign do_wr   = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_wr) wp_q <= wp_q + AW'(1);
            if (do_rd) rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wp_q] <= wr_data_i;
    end
endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: round-robin UART/button arbiter feeding a command FIFO whose
// entries play out as hold-then-gap pulses. CMD_SEQ_DROP_CNT_EN adds drop_cnt.
module cmd_sequencer
    import tama_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uart_data,
    input  logic       uart_valid,
    output logic       uart_ready,
    input  logic [5:0] btn,
    input  logic       is_sleeping,
    output logic [7:0] cmd_out,
    output logic       busy
`ifdef CMD_SEQ_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);
    seq_state_t state_q, state_d;
    rr_src_t    rr_q, rr_d;
    logic [7:0] cnt_q, cnt_d, cmd_q, cmd_d, out_q, head, fifo_din;
    logic [5:0] pend_q, pend_d, clr;
    logic [2:0] sel;
    logic       full, empty, pop, btn_req, uart_req, push_uart, push_btn;

    always_comb begin
        sel = '0;
        for (int i = 5; i >= 0; i--) if (pend_q[i]) sel = 3'(i);
    end

    assign btn_req    = |pend_q;
    assign uart_ready = !reset && !full && (!btn_req || rr_q == RR_UART);
    assign uart_req   = uart_valid && is_cmd(uart_data);
    assign push_uart  = uart_req && uart_ready;
    assign push_btn   = btn_req && !full && !push_uart;
    assign fifo_din   = push_uart ? uart_data : btn_code(sel);
    assign clr        = push_btn ? 6'(1) << sel : '0;
    // a pulse on the consuming edge re-arms the bit
    assign pend_d     = (pend_q & ~clr) | btn;
    assign rr_d       = (uart_req && btn_req && !full) ? (rr_q == RR_UART ? RR_BTN : RR_UART) : rr_q;

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (push_uart || push_btn),
        .wr_data_i(fifo_din),
        .rd_en_i  (pop),
        .full_o   (full),
        .empty_o  (empty),
        .head_o   (head)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: if (!empty) begin
                pop = 1'b1;
                if (!is_sleeping || head == CMD_WAKE) begin
                    cmd_d   = head;
                    cnt_d   = 8'(HOLD_CYCLES - 1);
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: if (cnt_q == '0) begin
                cmd_d   = CMD_NONE;
                cnt_d   = 8'(GAP_CYCLES - 1);
                state_d = S_GAP;
            end else cnt_d = cnt_q - 8'd1;
            S_GAP: if (cnt_q == '0) state_d = S_IDLE;
                   else cnt_d = cnt_q - 8'd1;
            default: state_d = S_IDLE;
        endcase
    end

    // out_q supplies the second cycle of accept-to-drive latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= RR_UART;
            cnt_q   <= '0;
            cmd_q   <= CMD_NONE;
            out_q   <= CMD_NONE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            out_q   <= cmd_q;
            pend_q  <= pend_d;
        end
    end

    assign cmd_out = out_q;
    assign busy    = state_q != S_IDLE || !empty;

`ifdef CMD_SEQ_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;
    logic [8:0] drop_sum;
    // a pop that leaves the FSM in IDLE is a sleep-filtered discard
    assign drop_sum = {1'b0, drop_q} + 9'(uart_valid && uart_ready && !is_cmd(uart_data))
                    + 9'(pop && state_d == S_IDLE);
    assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_q <= '0;
        else drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: directed tests with a queue-based behavioural model
// compared every cycle, plus hand-computed literal expectations.
module tb_cmd_sequencer;
    localparam int H = 4, G = 4, D = 4;

    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] uart_data = 8'h00;
    logic       uart_valid = 1'b0, uart_ready, is_sleeping = 1'b0, busy;
    logic [5:0] btn = '0;
    logic [7:0] cmd_out;
`ifdef CMD_SEQ_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    cmd_sequencer #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_data  (uart_data),
        .uart_valid (uart_valid),
        .uart_ready (uart_ready),
        .btn        (btn),
        .is_sleeping(is_sleeping),
        .cmd_out    (cmd_out),
        .busy       (busy)
`ifdef CMD_SEQ_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit valid_cmd(input logic [7:0] b);
        return b == 8'h65 || b == 8'h70 || b == 8'h64 || b == 8'h62 || b == 8'h73 || b == 8'h77;
    endfunction

    function automatic logic [7:0] code_of(input int i);
        logic [7:0] tbl [6] = '{8'h65, 8'h70, 8'h64, 8'h62, 8'h73, 8'h77};
        return tbl[i];
    endfunction

    // Model: commands queue in mq; each playout is a list of per-cycle values.
    logic [7:0] mq[$], play[$], played[$], want[$];
    logic [5:0] m_pend;
    bit         m_rr, m_full, m_rdy_now, m_ureq, m_breq;
    logic [7:0] m_cmd, m_out, c, prev_out = 8'h00;
    int         m_drop, lo;

    function automatic bit m_rdy();
        return !reset && mq.size() < D && (m_pend == 0 || !m_rr);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete(); play.delete();
            m_pend = '0; m_rr = 0; m_cmd = 8'h00; m_out = 8'h00; m_drop = 0;
        end else begin
            m_full = mq.size() == D;
            m_rdy_now = m_rdy();
            m_ureq = uart_valid && valid_cmd(uart_data);
            m_breq = m_pend != 0;
            m_out = m_cmd;
            if (play.size() != 0) void'(play.pop_front());
            else if (mq.size() != 0) begin
                c = mq.pop_front();
                if (is_sleeping && c != 8'h77) m_drop++;
                else begin
                    repeat (H) play.push_back(c);
                    repeat (G) play.push_back(8'h00);
                end
            end
            m_cmd = play.size() != 0 ? play[0] : 8'h00;
            lo = 0;
            for (int i = 5; i >= 0; i--) if (m_pend[i]) lo = i;
            if (uart_valid && m_rdy_now) begin
                if (m_ureq) mq.push_back(uart_data);
                else m_drop++;
            end
            if (!m_full && m_breq && !(uart_valid && m_rdy_now && m_ureq)) begin
                mq.push_back(code_of(lo));
                m_pend[lo] = 1'b0;
            end
            if (!m_full && m_breq && m_ureq) m_rr = !m_rr;
            m_pend = m_pend | btn;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cmd_out", cmd_out, m_out);
            chk("busy", busy, play.size() != 0 || mq.size() != 0);
            chk("uart_ready", uart_ready, m_rdy());
`ifdef CMD_SEQ_DROP_CNT_EN
            chk("drop_cnt", drop_cnt, m_drop > 255 ? 255 : m_drop);
`endif
            if (cmd_out != 8'h00 && cmd_out != prev_out) played.push_back(cmd_out);
            prev_out = cmd_out;
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send(input logic [7:0] b);
        bit acc = 0;
        uart_data = b;
        uart_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = uart_ready;
            @(posedge clk);
            #2;
        end
        uart_valid = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int k = 0; k < 400 && !idle; k++) begin
            @(negedge clk);
            idle = !busy;
        end
        chk("drain", idle, 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_played(input string name);
        chk({name, "_count"}, played.size(), want.size());
        for (int i = 0; i < want.size() && i < played.size(); i++) chk(name, played[i], want[i]);
        played.delete();
        want.delete();
    endtask

    initial begin
        logic [7:0] t1_out [11] = '{8'h00, 8'h00, 8'h65, 8'h65, 8'h65, 8'h65, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        bit         t1_busy [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_out", cmd_out, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_uart_ready", uart_ready, 0);
`ifdef CMD_SEQ_DROP_CNT_EN
        chk("rst_drop_cnt", drop_cnt, 0);
`endif
        @(posedge clk);
        #2 reset = 1'b0;

        send(8'h65);
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            chk("t1_pulse_out", cmd_out, t1_out[j]);
            chk("t1_pulse_busy", busy, t1_busy[j]);
        end
        @(posedge clk);
        #2;
        want.push_back(8'h65);
        check_played("t1_played");

        btn = 6'b000010;
        fork
            send(8'h64);
            begin @(posedge clk); #2 btn = '0; end
        join
        wait_idle();
        want.push_back(8'h64); want.push_back(8'h70);
        check_played("t2_order");

        send(8'h41);
        wait_idle();
        check_played("t4_invalid");
`ifdef CMD_SEQ_DROP_CNT_EN
        chk("t4_drop_cnt", drop_cnt, 1);
`endif

        is_sleeping = 1'b1;
        send(8'h65);
        send(8'h77);
        wait_idle();
        is_sleeping = 1'b0;
        want.push_back(8'h77);
        check_played("t5_sleep");
`ifdef CMD_SEQ_DROP_CNT_EN
        chk("t5_drop_cnt", drop_cnt, 2);
`endif

        send(8'h65); send(8'h70); send(8'h64); send(8'h73); send(8'h77);
        @(negedge clk);
        chk("t3_full_ready", uart_ready, 0);
        @(posedge clk);
        #2;
        fork
            send(8'h65);
            begin
                @(posedge clk); #2 btn = 6'b001000;
                @(posedge clk); #2 btn = '0;
                repeat (2) @(posedge clk);
                #2 btn = 6'b001000;
                @(posedge clk); #2 btn = '0;
            end
        join
        wait_idle();
        want.push_back(8'h65); want.push_back(8'h70); want.push_back(8'h64); want.push_back(8'h73);
        want.push_back(8'h77); want.push_back(8'h65); want.push_back(8'h62);
        check_played("t3_full");

        send(8'h73); send(8'h65); send(8'h70);
        @(negedge clk);
        chk("t6_pre_cmd_out", cmd_out, 8'h73);
        chk("t6_pre_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_cmd_out", cmd_out, 8'h00);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_uart_ready", uart_ready, 0);
`ifdef CMD_SEQ_DROP_CNT_EN
        chk("t6_rst_drop_cnt", drop_cnt, 0);
`endif
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("t6_post_uart_ready", uart_ready, 1);
        chk("t6_post_busy", busy, 0);
        chk("t6_post_cmd_out", cmd_out, 8'h00);
        played.delete();
        repeat (12) @(negedge clk);
        check_played("t6_flushed");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Sits between the command sources and the stats block; drives the 8-bit stats `inputs` bus.
- Arbitrates between two requesters, the UART receive byte stream and six push-buttons, with round-robin priority.
- Validates and queues commands, then plays each one out as a timed pulse: command byte held, then 8'h00 gap, so stats re-arms its once-per-press latch between commands.
- Drops commands that stats would ignore while sleeping.

Parameters:
- HOLD_CYCLES, 4: cycles the command byte is driven on cmd_out (range 1..255).
- GAP_CYCLES, 4: cycles of 8'h00 after each command (range 1..255).
- FIFO_DEPTH, 4: command queue entries (power of 2, 2..16).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- uart_data  in  8  ASCII byte from UART receiver.
- uart_valid  in  1  uart_data valid.
- uart_ready  out  1  byte accepted when uart_valid && uart_ready.
- btn  in  6  one-cycle button pulses: [0]'e' [1]'p' [2]'d' [3]'b' [4]'s' [5]'w'.
- is_sleeping  in  1  from stats.
- cmd_out  out  8  to stats inputs.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- drop_cnt  out  8  only with DROP_CNT_EN.

Behaviour:
- Reset values: cmd_out=8'h00, uart_ready=0, busy=0, FIFO empty, btn_pend=0, rr_ptr=UART, FSM=IDLE, drop_cnt=0.
- Valid command set: 8'h65, 8'h70, 8'h64, 8'h62, 8'h73, 8'h77.
- Invalid UART bytes are accepted (handshake completes) and discarded, never queued.
- Button latch:
  - Any btn[i]=1 sets btn_pend[i] on the same clock edge.
  - A bit that is already pending stays set; duplicates merge.
- Button request: asserted when btn_pend != 0. The selected bit is the lowest set index.
- uart_ready = !full && (!btn_req || rr_ptr==UART).
- FIFO write (at most one per cycle):
  - Only UART requests a valid byte: UART wins.
  - Only buttons request: the lowest pending button wins.
  - Both request: rr_ptr decides, then rr_ptr flips to the other source.
  - When a button is written, its pending bit clears.
  - A btn[i] pulse arriving on the same cycle its pending bit is consumed re-sets that bit.
- FIFO full: no writes. UART stalls (uart_ready=0) and button bits stay pending. Nothing is lost.
- A valid UART byte while uart_ready=0 must be held by the source.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE with FIFO non-empty: pop the head. If is_sleeping=1 and head != 8'h77, discard it and stay IDLE (one pop per cycle). Otherwise latch it into cmd_out, load cnt=HOLD_CYCLES-1, and go to DRIVE.
  - DRIVE: cmd_out holds the byte. When cnt==0, set cmd_out=8'h00, load cnt=GAP_CYCLES-1, and go to GAP. Otherwise decrement cnt.
  - GAP: cmd_out=8'h00. When cnt==0, go to IDLE. Otherwise decrement.
- Latency: a UART byte accepted at edge N into an empty FIFO with the FSM in IDLE appears on cmd_out after edge N+2. It is held exactly HOLD_CYCLES cycles, followed by exactly GAP_CYCLES zero cycles.
- FIFO push and pop in the same cycle when full is allowed: the pop frees the slot at the same edge, so uart_ready is computed from the registered full flag only.
- is_sleeping is sampled only at pop time. A change during DRIVE does not truncate the pulse.
- Reset mid-operation clears everything immediately, including cmd_out, whose next value is 8'h00 asynchronously.

Optional Feature:
- Macro: CMD_SEQ_DROP_CNT_EN.
- Defined:
  - drop_cnt increments by 1 per invalid UART byte and per sleep-filtered pop.
  - It saturates at 8'hFF.
  - Two drop events in one cycle (invalid byte plus filtered pop) add 2, with saturation.
- Not defined: drop_cnt port absent; no counter logic.

Decomposition:
- Shared package tama_pkg:
  - Command code constants CMD_EAT=8'h65, CMD_PLAY=8'h70, CMD_DOC=8'h64, CMD_BATH=8'h62, CMD_SLEEP=8'h73, CMD_WAKE=8'h77, CMD_NONE=8'h00.
  - btn-index-to-code mapping function.
  - FSM state enum seq_state_t.
- One sub-module: cmd_fifo, a synchronous FIFO with parameter DEPTH, width 8, outputs full/empty/head. The sequencer instantiates it once.

Test Plan:
- Single UART byte, HOLD=GAP=4 defaults:
  - Stimulus: uart_data=8'h65, valid for 1 cycle, FIFO empty.
  - Response: cmd_out=8'h65 for 4 cycles starting 2 cycles after acceptance, then 8'h00 for 4 cycles; busy drops after that.
- Simultaneous requests:
  - Stimulus: btn[1] and UART 8'h64 in the same cycle, rr_ptr=UART.
  - Response: queue order 8'h64 then 8'h70; cmd_out plays both, each with a gap.
- FIFO full:
  - Stimulus: 6 UART valid bytes back-to-back plus btn[3] pulse, with the FSM busy.
  - Response: uart_ready=0 after 4 entries; btn_pend[3] is retained; no byte is lost; all 6 bytes plus 8'h62 eventually output in accept order.
- Invalid byte:
  - Stimulus: UART 8'h41.
  - Response: handshake completes, cmd_out stays 8'h00; drop_cnt=1 with CMD_SEQ_DROP_CNT_EN.
- Sleep filter:
  - Stimulus: is_sleeping=1, queue 8'h65, 8'h77.
  - Response: 8'h65 is discarded; 8'h77 is driven for 4 cycles; drop_cnt +1.
- Reset during DRIVE:
  - Stimulus: assert reset with cmd_out=8'h73 and 2 FIFO entries.
  - Response: cmd_out=8'h00 immediately; FIFO empty; busy=0; uart_ready=1 after reset release.
